ramsdp_fifo_ctrl: RTL and testbench

//  Synchronous FIFO controller that sits directly in front of an external

---
 rtl/ramsdp_fifo_ctrl.sv | 100 ++++++++++
 tb/tb_ramsdp_fifo_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ramsdp_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ramsdp_fifo_ctrl
// Synchronous FIFO controller in front of an external simple-dual-port RAM
// (port A write, port B registered read with 1-cycle latency). Keeps only the
// pointers, the occupancy and the flags; the RAM holds the data.
//
// Ports
//   clk, nreset            clock, asynchronous active-low reset
//   clear                  synchronous flush
//   in_valid/in_data       push stream; in_ready (registered) = not full
//   out_valid/out_data     pop stream head; out_valid registered
//   out_ready              consumer accepts head
//   count                  committed occupancy 0..DEPTH (registered)
//   mem_we/mem_addr_a/mem_din   RAM port A write (combinational)
//   mem_addr_b/mem_dout_b       RAM port B read address / registered data
// ---------------------------------------------------------------------------
module ramsdp_fifo_ctrl #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 6
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [AW:0]   count,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr_a,
    output logic [DW-1:0] mem_din,
    output logic [AW-1:0] mem_addr_b,
    input  logic [DW-1:0] mem_dout_b
);

    localparam int unsigned CW    = AW + 1;
    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_in_ready;
    logic          r_out_valid;

    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_next;
    logic [CW-1:0] w_count_drain;

    // Handshakes; clear overrides both. nreset gates the write strobe so the
    // RAM is never written while reset is held.
    always_comb begin
        w_push        = in_valid & r_in_ready & ~clear & nreset;
        w_pop         = r_out_valid & out_ready & ~clear;
        w_count_next  = r_count + CW'(w_push) - CW'(w_pop);
        // Only entries committed before this cycle may become the next head:
        // a same-address write/read on the RAM returns stale data.
        w_count_drain = r_count - CW'(w_pop);
    end

    // RAM port drive; port B looks ahead to the entry that will be the head.
    always_comb begin
        mem_we     = w_push;
        mem_addr_a = r_wr_ptr;
        mem_din    = in_data;
        mem_addr_b = r_rd_ptr + AW'(w_pop);
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_wr_ptr    <= r_wr_ptr + AW'(w_push);
            r_rd_ptr    <= r_rd_ptr + AW'(w_pop);
            r_count     <= w_count_next;
            r_in_ready  <= (w_count_next != FULL_CNT);
            r_out_valid <= (w_count_drain != '0);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = mem_dout_b;
    assign count     = r_count;

endmodule

// File: tb/tb_ramsdp_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ramsdp_fifo_ctrl
// Directed bench for ramsdp_fifo_ctrl with AW=2 (DEPTH=4) and a behavioural
// simple-dual-port RAM (registered port-B read, old data on collision).
// ---------------------------------------------------------------------------
module tb_ramsdp_fifo_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 2;
    localparam int unsigned DEPTH = 2 ** AW;

    logic          clk;
    logic          nreset;
    logic          clear;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [AW:0]   count;
    logic          mem_we;
    logic [AW-1:0] mem_addr_a;
    logic [DW-1:0] mem_din;
    logic [AW-1:0] mem_addr_b;
    logic [DW-1:0] mem_dout_b;

    logic [DW-1:0] ram [DEPTH];

    int errors;
    int checks;

    ramsdp_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .count      (count),
        .mem_we     (mem_we),
        .mem_addr_a (mem_addr_a),
        .mem_din    (mem_din),
        .mem_addr_b (mem_addr_b),
        .mem_dout_b (mem_dout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External SDP RAM model
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr_a] <= mem_din;
        mem_dout_b <= ram[mem_addr_b];
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] exp_d;
        logic [AW-1:0] hold_addr;
        int pops;
        int guard;

        errors    = 0;
        checks    = 0;
        nreset    = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD;
        out_ready = 1'b0;
        mem_dout_b = '0;

        // Reset state, write strobe suppressed while in reset
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        in_valid = 1'b0;
        step();
        nreset = 1'b1;
        step();

        // 1: single word, 2-edge latency, then popped
        in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b1;
        #1;
        chk("t1_mem_we", 32'(mem_we), 32'd1);
        chk("t1_addr_a", 32'(mem_addr_a), 32'd0);
        step();
        in_valid = 1'b0;
        chk("t1_count1", 32'(count), 32'd1);
        chk("t1_ov_early", 32'(out_valid), 32'd0);
        step();
        chk("t1_ov", 32'(out_valid), 32'd1);
        chk("t1_data", out_data, 32'hA5);
        chk("t1_count_hold", 32'(count), 32'd1);
        step();
        chk("t1_count0", 32'(count), 32'd0);
        chk("t1_ov_off", 32'(out_valid), 32'd0);

        // 2: fill to DEPTH, extra push ignored
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'(i + 1);
            step();
        end
        chk("t2_count4", 32'(count), 32'd4);
        chk("t2_in_ready", 32'(in_ready), 32'd0);
        in_data = 32'h99;
        #1;
        chk("t2_we_full", 32'(mem_we), 32'd0);
        step();
        chk("t2_count_hold", 32'(count), 32'd4);
        chk("t2_head1", out_data, 32'd1);

        // 3: full, push+pop same cycle -> push rejected
        in_data = 32'h55; out_ready = 1'b1;
        #1;
        chk("t3_we", 32'(mem_we), 32'd0);
        step();
        in_valid = 1'b0;
        chk("t3_count3", 32'(count), 32'd3);
        chk("t3_in_ready", 32'(in_ready), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            chk("t2_pop_valid", 32'(out_valid), 32'd1);
            chk("t2_pop_order", out_data, 32'(i));
            step();
        end
        chk("t3_empty_ov", 32'(out_valid), 32'd0);
        chk("t3_empty_cnt", 32'(count), 32'd0);

        // 5: backpressure, head and port-B address hold
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h500;
        step();
        in_valid = 1'b0;
        step();
        chk("t5_ov", 32'(out_valid), 32'd1);
        hold_addr = mem_addr_b;
        chk("t5_addr_b", 32'(hold_addr), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 3);
            in_data  = 32'h501 + 32'(i);
            #1;
            chk("t5_data_hold", out_data, 32'h500);
            chk("t5_addr_hold", 32'(mem_addr_b), 32'(hold_addr));
            step();
            chk("t5_count", 32'(count), 32'(1 + ((i + 1 < 3) ? i + 1 : 3)));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_drain", out_data, 32'h500 + 32'(i));
            step();
        end
        chk("t5_count0", 32'(count), 32'd0);

        // 6: clear with count=3 and push active
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'h600 + 32'(i);
            step();
        end
        chk("t6_count3", 32'(count), 32'd3);
        in_data = 32'h6FF; clear = 1'b1; out_ready = 1'b1;
        #1;
        chk("t6_we", 32'(mem_we), 32'd0);
        step();
        clear = 1'b0;
        chk("t6_count0", 32'(count), 32'd0);
        chk("t6_ov", 32'(out_valid), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        in_data = 32'h11;
        #1;
        chk("t6_addr_a", 32'(mem_addr_a), 32'd0);
        step();
        in_valid = 1'b0;
        step();
        chk("t6_ov_after", 32'(out_valid), 32'd1);
        chk("t6_first", out_data, 32'h11);
        step();
        chk("t6_empty", 32'(count), 32'd0);

        // 4: steady stream, 1 word/cycle, ordering across wrap
        exp_d = 32'h1000;
        pops = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h1000 + 32'(i);
            #1;
            if (out_valid) begin
                chk("t4_order", out_data, exp_d);
                exp_d++;
                pops++;
            end
            if (i >= 2) chk("t4_count", 32'(count), 32'd2);
            step();
        end
        in_valid = 1'b0;
        chk("t4_throughput", 32'(pops), 32'd98);
        guard = 0;
        while ((count != 0) && (guard < 10)) begin
            if (out_valid) begin
                chk("t4_tail", out_data, exp_d);
                exp_d++;
                pops++;
            end
            step();
            guard++;
        end
        chk("t4_drain_bound", 32'(guard < 10), 32'd1);
        chk("t4_total", 32'(pops), 32'd100);

        // Async reset mid-stream drops contents
        in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
        step(); step();
        #2 nreset = 1'b0;
        #1;
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_ov", 32'(out_valid), 32'd0);
        chk("ar_we", 32'(mem_we), 32'd0);
        in_valid = 1'b0;
        step();
        nreset = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
